// File: rtl/add_chk_pkg.sv
// Shared types and helpers for the adder response checker.
package add_chk_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } status_e;

    // Saturating increment of a counter that is w bits wide (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] maxv;
        maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= maxv) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/add_chk_delay.sv
// Valid+data shift pipe of DEPTH stages; reset clears only the valid bits,
// flush empties the pipe synchronously.
module add_chk_delay #(
    parameter int DEPTH = 1,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DW-1:0]    dat_q [DEPTH];
    logic [DW-1:0]    dat_d [DEPTH];

    always_comb begin
        vld_d[0] = in_valid & ~flush;
        dat_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1] & ~flush;
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    // Payload is only meaningful alongside its valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        dat_q <= dat_d;
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/add_resp_checker.sv
// Response checker for a registered adder: predicts a+b, delays it LATENCY cycles,
// compares with sum. Define ADD_RESP_CHECKER_HALT_EN to freeze on the first mismatch.
module add_resp_checker
    import add_chk_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = 1,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [WIDTH-1:0] exp_sum,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       status
);

    logic             halted;
    logic             pipe_vld;
    logic [WIDTH-1:0] pipe_dat;
    logic [WIDTH-1:0] pred;
    logic             cmp_en;
    logic             cmp_miss;

    logic             chk_valid_q, chk_valid_d;
    logic             mismatch_q,  mismatch_d;
    logic [WIDTH-1:0] exp_sum_q,   exp_sum_d;
    logic [CNT_W-1:0] chk_cnt_q,   chk_cnt_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
    status_e          status_q,    status_d;

`ifdef ADD_RESP_CHECKER_HALT_EN
    assign halted = (status_q == ST_FAIL);
`else
    assign halted = 1'b0;
`endif

    // Carry is dropped, matching the adder's truncated result.
    assign pred = a + b;

    add_chk_delay #(
        .DEPTH (LATENCY),
        .DW    (WIDTH)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .flush     (clear),
        .in_valid  (in_valid & ~halted),
        .in_data   (pred),
        .out_valid (pipe_vld),
        .out_data  (pipe_dat)
    );

    assign cmp_en   = pipe_vld & ~clear & ~halted;
    assign cmp_miss = (sum !== pipe_dat);

    always_comb begin
        chk_valid_d = 1'b0;
        mismatch_d  = mismatch_q;
        exp_sum_d   = exp_sum_q;
        chk_cnt_d   = chk_cnt_q;
        err_cnt_d   = err_cnt_q;
        status_d    = status_q;
        if (clear) begin
            mismatch_d = 1'b0;
            chk_cnt_d  = '0;
            err_cnt_d  = '0;
            status_d   = ST_IDLE;
        end else if (cmp_en) begin
            chk_valid_d = 1'b1;
            mismatch_d  = cmp_miss;
            exp_sum_d   = pipe_dat;
            chk_cnt_d   = CNT_W'(sat_inc(32'(chk_cnt_q), CNT_W));
            if (cmp_miss) begin
                err_cnt_d = CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
                status_d  = ST_FAIL;
            end else if (status_q == ST_IDLE) begin
                status_d  = ST_PASS;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            exp_sum_q   <= '0;
            chk_cnt_q   <= '0;
            err_cnt_q   <= '0;
            status_q    <= ST_IDLE;
        end else begin
            chk_valid_q <= chk_valid_d;
            mismatch_q  <= mismatch_d;
            exp_sum_q   <= exp_sum_d;
            chk_cnt_q   <= chk_cnt_d;
            err_cnt_q   <= err_cnt_d;
            status_q    <= status_d;
        end
    end

    assign chk_valid = chk_valid_q;
    assign mismatch  = mismatch_q;
    assign exp_sum   = exp_sum_q;
    assign chk_cnt   = chk_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign status    = status_q;

endmodule

// File: tb/tb_add_resp_checker.sv
// Directed bench: three checker instances (latency 1, latency 3, 4-bit counters)
// fed from bench-side adder models.
module tb_add_resp_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst3 = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sum_force = 1'b0;

    logic [31:0] add_q;
    logic [31:0] s1_q, s2_q, s3_q;
    logic [31:0] sum0;
    logic        rst_u3;

    logic        cv0, mm0, cv3, mm3, cv4, mm4;
    logic [31:0] es0, es3, es4;
    logic [15:0] cc0, ec0, cc3, ec3;
    logic [3:0]  cc4, ec4;
    logic [1:0]  st0, st3, st4;

    int total = 0;
    int bad   = 0;
    int pulses;

    always #5 clk = ~clk;

    // Reference adders: 1-cycle for u0/u4, 3-cycle for u3.
    always @(posedge clk) begin
        add_q <= a + b;
        s1_q  <= a + b;
        s2_q  <= s1_q;
        s3_q  <= s2_q;
    end

    assign sum0   = sum_force ? 32'h0 : add_q;
    assign rst_u3 = rst | rst3;

    add_resp_checker #(.WIDTH(32), .LATENCY(1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .a(a), .b(b),
        .sum(sum0), .chk_valid(cv0), .mismatch(mm0), .exp_sum(es0),
        .chk_cnt(cc0), .err_cnt(ec0), .status(st0));

    add_resp_checker #(.WIDTH(32), .LATENCY(3), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst_u3), .clear(clear), .in_valid(in_valid), .a(a), .b(b),
        .sum(s3_q), .chk_valid(cv3), .mismatch(mm3), .exp_sum(es3),
        .chk_cnt(cc3), .err_cnt(ec3), .status(st3));

    add_resp_checker #(.WIDTH(32), .LATENCY(1), .CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .a(a), .b(b),
        .sum(sum0), .chk_valid(cv4), .mismatch(mm4), .exp_sum(es4),
        .chk_cnt(cc4), .err_cnt(ec4), .status(st4));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_txn(input logic [31:0] ta, input logic [31:0] tb);
        a        = ta;
        b        = tb;
        in_valid = 1'b1;
        tick();
        $display("txn a=0x%08h b=0x%08h chk_valid=%0b exp_sum=0x%08h chk_cnt=%0d status=%0d",
                 ta, tb, cv0, es0, cc0, st0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_val("rst_chk_valid", cv0, 0);
        check_val("rst_mismatch", mm0, 0);
        check_val("rst_exp_sum", es0, 0);
        check_val("rst_chk_cnt", cc0, 0);
        check_val("rst_err_cnt", ec0, 0);
        check_val("rst_status", st0, 0);
        rst = 1'b0;
        tick();

        // Single transaction 5+0
        drive_txn(32'd5, 32'd0);
        in_valid = 1'b0;
        check_val("single_early", cv0, 0);
        tick();
        check_val("single_chk_valid", cv0, 1);
        check_val("single_mismatch", mm0, 0);
        check_val("single_exp_sum", es0, 5);
        check_val("single_chk_cnt", cc0, 1);
        check_val("single_status", st0, 1);
        tick();
        check_val("single_pulse_end", cv0, 0);
        check_val("single_exp_hold", es0, 5);

        // Streaming 100 back-to-back transactions
        do_clear();
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            drive_txn(32'd5, 32'(i));
            if (cv0) pulses++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cv0) pulses++;
        end
        check_val("stream_pulses", 64'(pulses), 100);
        check_val("stream_chk_cnt", cc0, 100);
        check_val("stream_err_cnt", ec0, 0);
        check_val("stream_status", st0, 1);
        check_val("stream_last_exp", es0, 104);
        check_val("lat3_stream_cnt", cc3, 100);
        check_val("lat3_stream_err", ec3, 0);
        check_val("sat4_chk_cnt", cc4, 15);
        check_val("sat4_err_cnt", ec4, 0);

        // Wrap-around
        drive_txn(32'hFFFF_FFFF, 32'd2);
        in_valid = 1'b0;
        tick();
        check_val("wrap_chk_valid", cv0, 1);
        check_val("wrap_exp_sum", es0, 1);
        check_val("wrap_mismatch", mm0, 0);

        // Injected fault at compare 3, then 10 good compares
        do_clear();
        for (int k = 0; k < 13; k++) begin
            drive_txn(32'd3, 32'd4);
            in_valid  = 1'b0;
            sum_force = (k == 2);
            tick();
            sum_force = 1'b0;
            if (k == 2) begin
                check_val("fault_chk_valid", cv0, 1);
                check_val("fault_mismatch", mm0, 1);
                check_val("fault_exp_sum", es0, 7);
                check_val("fault_err_cnt", ec0, 1);
                check_val("fault_status", st0, 2);
            end
        end
        check_val("fault_sticky_status", st0, 2);
        check_val("fault_sticky_err", ec0, 1);
`ifdef ADD_RESP_CHECKER_HALT_EN
        check_val("halt_chk_cnt", cc0, 3);
        check_val("halt_exp_sum", es0, 7);
`else
        check_val("run_chk_cnt", cc0, 13);
`endif

        // Clear colliding with a pending compare
        do_clear();
        check_val("clear_status", st0, 0);
        drive_txn(32'd1, 32'd2);
        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        check_val("collide_chk_valid", cv0, 0);
        check_val("collide_chk_cnt", cc0, 0);
        check_val("collide_err_cnt", ec0, 0);
        check_val("collide_status", st0, 0);
        tick();
        check_val("collide_no_stale", cv0, 0);

        // Clear colliding with a capture
        a = 32'd1; b = 32'd1; in_valid = 1'b1; clear = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0;
        tick();
        check_val("capclr_chk_valid", cv0, 0);
        check_val("capclr_chk_cnt", cc0, 0);

        // Async reset mid-stream on the latency-3 instance
        do_clear();
        for (int i = 0; i < 4; i++) drive_txn(32'd10, 32'(i));
        in_valid = 1'b0;
        check_val("lat3_first_valid", cv3, 1);
        check_val("lat3_first_exp", es3, 10);
        check_val("lat3_first_cnt", cc3, 1);
        rst3 = 1'b1;
        #1;
        check_val("arst_chk_valid", cv3, 0);
        check_val("arst_chk_cnt", cc3, 0);
        check_val("arst_exp_sum", es3, 0);
        check_val("arst_status", st3, 0);
        #2;
        rst3 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cv3) pulses++;
        end
        check_val("arst_no_stale", 64'(pulses), 0);
        check_val("arst_cnt_after", cc3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
